// File: rtl/board_controller.sv
// board_controller
//   Owns the 3x3 tic-tac-toe board. A rising edge on the place key writes the
//   current player's mark into the box selected by curBox, flips the turn and
//   bumps the move counter. Once the game is over the board is frozen until
//   reset.
//
// Ports
//   clk        system clock
//   reset      synchronous active-high reset
//   place      debounced place key (level), one move per rising edge
//   curBox     selected box, 0..8 valid, 9..15 means nothing selected
//   gameOver   level from the victory checker
//   out0..out8 box contents: 00 empty, 01 player 1, 10 player 2
//   turn       mark the next accepted move will write
//   moveCount  accepted moves, 0..9
//   placed     one-cycle pulse the cycle after a move is accepted
//   rejected   one-cycle pulse the cycle after a place edge is refused
//   active     1 while the game is in play
//
// State | Meaning
// ------+---------------------------------------------------------
// PLAY  | game running, place edges are accepted or refused
// DONE  | line of three or full board, edges ignored, board held
module board_controller #(
  parameter logic [1:0] FIRST_MARK = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       place,
  input  logic [3:0] curBox,
  input  logic       gameOver,
  output logic [1:0] out0,
  output logic [1:0] out1,
  output logic [1:0] out2,
  output logic [1:0] out3,
  output logic [1:0] out4,
  output logic [1:0] out5,
  output logic [1:0] out6,
  output logic [1:0] out7,
  output logic [1:0] out8,
  output logic [1:0] turn,
  output logic [3:0] moveCount,
  output logic       placed,
  output logic       rejected,
  output logic       active
);

  typedef enum logic {PLAY = 1'b0, DONE = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] board_q [9];
  logic [1:0] board_d [9];
  logic [1:0] turn_q, turn_d;
  logic [3:0] cnt_q, cnt_d;
  logic       place_q;
  logic       placed_q, placed_d;
  logic       rejected_q, rejected_d;
  logic       place_edge;
  logic       box_free;

  assign place_edge = place & ~place_q;

  // Out-of-range indices (9..15) never match, so they read as "not free".
  always_comb begin
    box_free = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (curBox == 4'(i) && board_q[i] == 2'b00) box_free = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    cnt_d      = cnt_q;
    placed_d   = 1'b0;
    rejected_d = 1'b0;
    unique case (state_q)
      PLAY: begin
        if (gameOver) begin
          // gameOver beats a simultaneous edge: refuse it and stop.
          state_d    = DONE;
          rejected_d = place_edge;
        end else if (place_edge) begin
          if (box_free) begin
            for (int i = 0; i < 9; i++) begin
              if (curBox == 4'(i)) board_d[i] = turn_q;
            end
            turn_d   = ~turn_q;
            cnt_d    = cnt_q + 4'd1;
            placed_d = 1'b1;
            if (cnt_q == 4'd8) state_d = DONE;
          end else begin
            rejected_d = 1'b1;
          end
        end
      end
      DONE: begin
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PLAY;
      for (int i = 0; i < 9; i++) board_q[i] <= 2'b00;
      turn_q     <= FIRST_MARK;
      cnt_q      <= 4'd0;
      // Start high so a key held through reset release is not an edge.
      place_q    <= 1'b1;
      placed_q   <= 1'b0;
      rejected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      turn_q     <= turn_d;
      cnt_q      <= cnt_d;
      place_q    <= place;
      placed_q   <= placed_d;
      rejected_q <= rejected_d;
    end
  end

  assign out0      = board_q[0];
  assign out1      = board_q[1];
  assign out2      = board_q[2];
  assign out3      = board_q[3];
  assign out4      = board_q[4];
  assign out5      = board_q[5];
  assign out6      = board_q[6];
  assign out7      = board_q[7];
  assign out8      = board_q[8];
  assign turn      = turn_q;
  assign moveCount = cnt_q;
  assign placed    = placed_q;
  assign rejected  = rejected_q;
  assign active    = (state_q == PLAY);

endmodule

// File: doc/board_controller.md
Name: board_controller

Overview:
- Owns the 3x3 tic-tac-toe board register and produces out0..out8 for boxSelector, the victory checker and the LED renderer.
- Consumes curBox from boxSelector plus a debounced "place" key, and writes the current player's mark into the selected box.
- Alternates turns, counts moves and freezes the board once the game is over.
- Its one-cycle "placed" pulse drives boxSelector's next input, so the cursor advances after every move.

Parameters:
FIRST_MARK, 2'b01, mark encoding of the player who moves first after reset (legal values 2'b01 or 2'b10).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
place  input  1  debounced, synchronized place key (level); one move per rising edge
curBox  input  4  box index from boxSelector; 0..8 valid, 9..15 means no box selected
gameOver  input  1  level from victory checker; high once a line of three exists
out0..out8  output  2 each  box contents: 00 empty, 01 player 1, 10 player 2, 11 never driven
turn  output  2  mark that the next accepted move will write (01 or 10)
moveCount  output  4  number of accepted moves, 0..9
placed  output  1  one-cycle pulse, the cycle after a move is accepted
rejected  output  1  one-cycle pulse, the cycle after a place edge is refused
active  output  1  1 in PLAY state, 0 in DONE state

Behaviour:
- All state changes occur on posedge clk. reset dominates every other input, including mid-game.
- Reset values:
  - out0..out8 = 00, turn = FIRST_MARK, moveCount = 0.
  - placed = 0, rejected = 0, state = PLAY, active = 1.
  - Internal place_q = 1, so a key held through reset release does not produce a move.
- Edge detect: edge = place & ~place_q. place_q <= place every cycle.
- FSM has two states, PLAY and DONE.
  - In PLAY, an edge is accepted iff gameOver == 0, curBox <= 8 and out[curBox] == 00.
  - Accept at posedge k:
    - out[curBox] <= turn; turn <= ~turn (01<->10); moveCount <= moveCount + 1.
    - placed = 1 for the cycle after k.
    - Board outputs show the new mark in the same cycle that placed is high (latency 1).
  - Refused edge in PLAY (occupied box, curBox > 8, or gameOver high): board, turn and moveCount are unchanged, and rejected = 1 for one cycle.
  - PLAY -> DONE when gameOver is sampled high, or on the accept that makes moveCount = 9.
    - DONE is visible (active = 0) in the same cycle as the 9th placed pulse.
  - If gameOver and an edge occur in the same cycle, gameOver wins: the move is refused with a rejected pulse and the FSM goes to DONE.
  - In DONE, all place edges are ignored (no placed, no rejected pulse) and the board is held. Only reset leaves DONE.
- Holding place high for many cycles produces at most one accept or reject.
- moveCount never exceeds 9 and never wraps.
- placed and rejected are never high in the same cycle.

Test Plan:
- Reset, then place edges with curBox = 4, then 0 -> out4 = 01, out0 = 10, turn = 01, moveCount = 2, exactly two one-cycle placed pulses.
- Place edge with curBox = 4 while out4 = 01 -> rejected pulse, board unchanged, turn and moveCount unchanged.
- place held high across reset release, and held high for 10 cycles afterwards -> no accept at release; exactly one move on the next fresh edge only.
- gameOver asserted in the same cycle as a place edge with curBox = 2 -> out2 stays 00, rejected pulse, active = 0; later edges produce no pulses.
- Nine accepted moves into boxes 0..8 -> alternating marks starting with FIRST_MARK, moveCount = 9, active = 0; a 10th edge is ignored.
- Reset asserted mid-game with moveCount = 5 -> next cycle all boxes 00, moveCount = 0, turn = FIRST_MARK, active = 1.
